fp_mul_arbiter: RTL

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter_if.sv | 42 ++++
 rtl/fp_mul_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter_if.sv
// rtl/fp_mul_arbiter_if.sv - request/response/multiplier bundle for fp_mul_arbiter
// slave: the arbiter; master: requesters, consumers and the shared multiplier.
interface fp_mul_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       req0_ready;
    logic       req1_ready;
    logic       rsp0_valid;
    logic       rsp1_valid;
    logic [7:0] rsp0_data;
    logic [7:0] rsp1_data;
    logic       rsp0_ready;
    logic       rsp1_ready;
    logic [7:0] mul_a;
    logic [7:0] mul_b;
    logic [7:0] mul_product;
    logic       busy;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        input  rsp0_ready, rsp1_ready,
        output mul_a, mul_b,
        input  mul_product,
        output busy
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
        output rsp0_ready, rsp1_ready,
        input  mul_a, mul_b,
        output mul_product,
        input  busy
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - two-port round-robin front end for a shared fixed-latency multiplier
// Credits cover in-flight plus buffered results, so a per-port FIFO can never overflow.
module fp_mul_arbiter #(
    parameter int LAT    = 8,
    parameter int RDEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    fp_mul_arbiter_if.slave bus
);
    localparam int CW = $clog2(RDEPTH + 1);
    localparam int PW = $clog2(RDEPTH);

    logic [1:0]    req_valid;
    logic [1:0]    rsp_ready;
    logic [1:0]    elig;
    logic [1:0]    gnt;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    rsp_valid;

    logic          ptr_q, ptr_d;
    logic [7:0]    mul_a_q, mul_a_d;
    logic [7:0]    mul_b_q, mul_b_d;
    logic [LAT:0]  tag_vld_q, tag_vld_d;
    logic [LAT:0]  tag_port_q, tag_port_d;
    logic [CW-1:0] credit_q [2];
    logic [CW-1:0] credit_d [2];
    logic [CW-1:0] count_q [2];
    logic [CW-1:0] count_d [2];
    logic [PW-1:0] wr_q [2];
    logic [PW-1:0] wr_d [2];
    logic [PW-1:0] rd_q [2];
    logic [PW-1:0] rd_d [2];
    logic [7:0]    mem_q [2][RDEPTH];
    logic [7:0]    mem_d [2][RDEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
        return (v == PW'(RDEPTH - 1)) ? '0 : v + PW'(1);
    endfunction

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    assign elig[0] = !reset && req_valid[0] && (credit_q[0] != '0);
    assign elig[1] = !reset && req_valid[1] && (credit_q[1] != '0);
    assign gnt[0]  = elig[0] && (!elig[1] || !ptr_q);
    assign gnt[1]  = elig[1] && (!elig[0] || ptr_q);

    // The last tag stage lines up with the product of the operands issued LAT+1 edges ago.
    assign push[0] = tag_vld_q[LAT] && !tag_port_q[LAT];
    assign push[1] = tag_vld_q[LAT] &&  tag_port_q[LAT];

    assign rsp_valid[0] = !reset && (count_q[0] != '0);
    assign rsp_valid[1] = !reset && (count_q[1] != '0);
    assign pop          = rsp_valid & rsp_ready;

    always_comb begin
        ptr_d      = ptr_q;
        mul_a_d    = 8'h00;
        mul_b_d    = 8'h00;
        tag_vld_d  = {tag_vld_q[LAT-1:0], gnt[0] | gnt[1]};
        tag_port_d = {tag_port_q[LAT-1:0], gnt[1]};
        if (gnt[0]) begin
            ptr_d   = 1'b1;
            mul_a_d = bus.req0_a;
            mul_b_d = bus.req0_b;
        end else if (gnt[1]) begin
            ptr_d   = 1'b0;
            mul_a_d = bus.req1_a;
            mul_b_d = bus.req1_b;
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < 2; p++) begin
            wr_d[p]     = wr_q[p];
            rd_d[p]     = rd_q[p];
            count_d[p]  = count_q[p] + CW'(push[p]) - CW'(pop[p]);
            credit_d[p] = credit_q[p] - CW'(gnt[p]) + CW'(pop[p]);
            if (push[p]) begin
                mem_d[p][wr_q[p]] = bus.mul_product;
                wr_d[p]           = ptr_inc(wr_q[p]);
            end
            if (pop[p]) begin
                rd_d[p] = ptr_inc(rd_q[p]);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            ptr_q      <= 1'b0;
            mul_a_q    <= 8'h00;
            mul_b_q    <= 8'h00;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
            for (int p = 0; p < 2; p++) begin
                credit_q[p] <= CW'(RDEPTH);
                count_q[p]  <= '0;
                wr_q[p]     <= '0;
                rd_q[p]     <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            credit_q   <= credit_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push[0] && count_q[0] == CW'(RDEPTH)));
            assert (!(push[1] && count_q[1] == CW'(RDEPTH)));
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp0_data  = mem_q[0][rd_q[0]];
    assign bus.rsp1_data  = mem_q[1][rd_q[1]];
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.busy       = !reset && ((|tag_vld_q) || (count_q[0] != '0) || (count_q[1] != '0));
endmodule
